adder_axi_master: RTL and testbench
===================================

// Module: adder_axi_master
// PURPOSE
//  AXI4-Lite initiator that drives the memory-mapped adder peripheral. It writes operand A (0x00) and operand B (0x04),
//  then reads the sum (0x08) and the overflow flag (0x0C), and returns both on a simple start/done command port.
//  Sits between local control logic and the AXI-Lite interconnect; one outstanding transaction at a time.
// PARAMETERS
//  DATA_WIDTH      32   AXI data width; operand/sum width
//  ADDR_WIDTH      8    AXI address width
//  BASE_ADDR       0    peripheral base; register offsets are added to it
//  TIMEOUT_CYCLES  256  watchdog limit per channel wait (used only with ADDER_MASTER_TIMEOUT_EN)
// PORTS
//  m1_axi_aclk     in   1             clock
//  m1_axi_areset   in   1             reset, synchronous, active-high
//  start           in   1             begin operation; sampled only in IDLE
//  op_a, op_b      in   DATA_WIDTH    operands, captured on accepted start
//  busy            out  1             high from accepted start until done
//  done            out  1             one-cycle pulse at end of operation
//  sum             out  DATA_WIDTH    read-back sum, held until next done
//  overflow        out  1             bit 0 of 0x0C read, held until next done
//  err             out  1             any SLVERR/DECERR (or timeout) during the operation; valid with done
//  m1_axi_awaddr/awvalid/awready  out/out/in  ADDR_WIDTH/1/1   write address channel
//  m1_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
//  m1_axi_bresp/bvalid/bready     in/in/out   2/1/1            write response channel
//  m1_axi_araddr/arvalid/arready  out/out/in  ADDR_WIDTH/1/1   read address channel
//  m1_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  read data channel
// BEHAVIOUR
//  Reset: state=IDLE; every valid/ready output, busy, done, err, overflow = 0; sum = 0; addr/wdata = 0; wstrb = all ones.
//  FSM: IDLE -> WA_REQ -> WA_RSP -> WB_REQ -> WB_RSP -> RS_REQ -> RS_RSP -> RO_REQ -> RO_RSP -> DONE -> IDLE.
//  IDLE: start=1 -> capture op_a/op_b, clear err, set busy, go to WA_REQ. start is ignored while busy.
//  Wx_REQ: assert awvalid and wvalid together (awaddr=BASE+0x00/0x04, wdata=operand, wstrb all ones).
//    Each valid drops the cycle after its own ready is seen; AW and W may complete in either order or together.
//    Leave the state when both have completed. Addr/data stay stable while valid is high.
//  Wx_RSP: bready=1; on bvalid, bresp[1]=1 sets err; go to the next state. bready drops the cycle after.
//  Rx_REQ: arvalid=1, araddr=BASE+0x08/0x0C, held until arready; then go to Rx_RSP.
//  Rx_RSP: rready=1; on rvalid, capture rdata into the sum/overflow shadow; rresp[1]=1 sets err.
//  OKAY (00) and EXOKAY (01) both count as success.
//  DONE: update sum/overflow outputs from the shadows, pulse done for 1 cycle, clear busy, go to IDLE.
//  Latency: with every ready seen on the first valid cycle and every response on the next cycle,
//    start is sampled in cycle 0, the first valid asserts in cycle 1, and done asserts in cycle 9.
//  Error does not abort: the sequence always completes, and sum/overflow are still updated.
//  Reset mid-operation: the next edge returns to IDLE, all valids drop, and no done is issued.
//  Stray bvalid/rvalid outside the RSP states is ignored (ready is low).
// CONFIGURATION
//  ADDER_MASTER_TIMEOUT_EN defined: a watchdog counts cycles in each REQ/RSP state.
//    At TIMEOUT_CYCLES it drops the valid/ready of that channel, sets err, and jumps to DONE.
//    sum/overflow then hold their previous values.
//  Not defined: no counter; the FSM waits indefinitely for each handshake.
// STRUCTURE
//  Package adder_axi_pkg: state enum, register offsets (OFS_OP_A=0x00, OFS_OP_B=0x04, OFS_SUM=0x08, OFS_OVF=0x0C),
//    AXI response codes (OKAY/EXOKAY/SLVERR/DECERR).
//  Sub-module adder_axi_wdog: watchdog counter with clear/enable/expire, instantiated only under ADDER_MASTER_TIMEOUT_EN.
//  Everything else is a single FSM in this module.
// TESTING
//  1. Zero-wait slave; op_a=5, op_b=7, slave returns 12 and 0 -> sum=12, overflow=0, err=0, done in cycle 9.
//  2. op_a=0xFFFF_FFFF, op_b=1, slave returns 0 and 1 -> sum=0, overflow=1.
//  3. Slave delays awready 3 cycles after wready -> wvalid drops after 1 cycle, awvalid holds 4; data stays stable.
//  4. bresp=2'b10 on the operand B write -> sequence completes, err=1 with done, sum still updated.
//  5. start pulsed while busy; reset pulsed in RS_RSP -> no second op; after reset, IDLE with outputs 0 and no done.
//  6. With ADDER_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready never asserts -> arvalid drops after 16 cycles, err=1, done.

Source files
------------

// File: rtl/adder_axi_pkg.sv
// Shared definitions for the adder AXI4-Lite initiator.
// Contents: FSM state type, adder peripheral register offsets, AXI response codes and a helper
// that classifies a response as an error.
package adder_axi_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StWaReq,
        StWaRsp,
        StWbReq,
        StWbRsp,
        StRsReq,
        StRsRsp,
        StRoReq,
        StRoRsp,
        StDone
    } state_e;

    localparam logic [7:0] OFS_OP_A = 8'h00;
    localparam logic [7:0] OFS_OP_B = 8'h04;
    localparam logic [7:0] OFS_SUM  = 8'h08;
    localparam logic [7:0] OFS_OVF  = 8'h0C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // OKAY and EXOKAY are both success; only SLVERR/DECERR flag an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/adder_axi_wdog.sv
// Watchdog counter for one channel wait of the adder AXI initiator.
// Ports:
//   clk     clock
//   rst     synchronous active-high reset
//   clr     restart the count (state change)
//   en      count this cycle (FSM is waiting on a channel)
//   expire  high in the LIMIT-th consecutive enabled cycle
module adder_axi_wdog #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;

    assign expire = en && (count_q == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (en && !expire) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/adder_axi_master.sv
// AXI4-Lite initiator for the memory-mapped adder peripheral.
// Writes operand A (BASE+0x00) and operand B (BASE+0x04), reads the sum (BASE+0x08) and the
// overflow flag (BASE+0x0C), then reports them on a start/done command port. One outstanding
// transaction at a time.
// Ports:
//   m1_axi_aclk / m1_axi_areset  clock, synchronous active-high reset
//   start, op_a, op_b            command; sampled only in idle
//   busy, done                   operation in progress / one-cycle completion pulse
//   sum, overflow, err           results, held until the next done; err valid with done
//   m1_axi_aw*, w*, b*, ar*, r*  AXI4-Lite master channels
// Build option: define ADDER_MASTER_TIMEOUT_EN to add a per-wait watchdog (TIMEOUT_CYCLES) that
// abandons a stalled channel, sets err and finishes without updating sum/overflow.
module adder_axi_master
    import adder_axi_pkg::*;
#(
    parameter int unsigned               DATA_WIDTH     = 32,
    parameter int unsigned               ADDR_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0]     BASE_ADDR      = '0,
    parameter int unsigned               TIMEOUT_CYCLES = 256
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_areset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   sum,
    output logic                    overflow,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic [1:0]              m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic [1:0]              m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_OP_A = BASE_ADDR + ADDR_WIDTH'(OFS_OP_A);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OP_B = BASE_ADDR + ADDR_WIDTH'(OFS_OP_B);
    localparam logic [ADDR_WIDTH-1:0] ADDR_SUM  = BASE_ADDR + ADDR_WIDTH'(OFS_SUM);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OVF  = BASE_ADDR + ADDR_WIDTH'(OFS_OVF);

    state_e                  state_q, state_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic [DATA_WIDTH-1:0]   sum_q, sum_d;
    logic                    ovf_q, ovf_d;
    logic                    err_q, err_d;
    logic                    is_wreq;
    logic                    timeout;

    // Channel controls decode straight from registered state, so they are glitch-free.
    assign is_wreq        = (state_q == StWaReq) || (state_q == StWbReq);
    assign m1_axi_awvalid = is_wreq && !aw_done_q;
    assign m1_axi_wvalid  = is_wreq && !w_done_q;
    assign m1_axi_bready  = (state_q == StWaRsp) || (state_q == StWbRsp);
    assign m1_axi_arvalid = (state_q == StRsReq) || (state_q == StRoReq);
    assign m1_axi_rready  = (state_q == StRsRsp) || (state_q == StRoRsp);
    assign m1_axi_awaddr  = awaddr_q;
    assign m1_axi_araddr  = araddr_q;
    assign m1_axi_wdata   = wdata_q;
    assign m1_axi_wstrb   = '1;

    assign busy     = (state_q != StIdle) && (state_q != StDone);
    assign done     = (state_q == StDone);
    assign sum      = sum_q;
    assign overflow = ovf_q;
    assign err      = err_q;

`ifdef ADDER_MASTER_TIMEOUT_EN
    logic wdog_en;
    logic wdog_clr;

    assign wdog_en  = (state_q != StIdle) && (state_q != StDone);
    assign wdog_clr = (state_d != state_q);

    adder_axi_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (m1_axi_aclk),
        .rst    (m1_axi_areset),
        .clr    (wdog_clr),
        .en     (wdog_en),
        .expire (timeout)
    );
`else
    // Watchdog absent: TIMEOUT_CYCLES has no effect in this build.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        op_b_d    = op_b_q;
        sum_sh_d  = sum_sh_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StWaReq;
                    awaddr_d  = ADDR_OP_A;
                    wdata_d   = op_a;
                    op_b_d    = op_b;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            StWaReq, StWbReq: begin
                // AW and W complete independently; leave once both have handshaken.
                if (m1_axi_awvalid && m1_axi_awready) aw_done_d = 1'b1;
                if (m1_axi_wvalid && m1_axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    state_d   = (state_q == StWaReq) ? StWaRsp : StWbRsp;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            StWaRsp: begin
                if (m1_axi_bvalid) begin
                    err_d    = err_q | resp_is_err(m1_axi_bresp);
                    state_d  = StWbReq;
                    awaddr_d = ADDR_OP_B;
                    wdata_d  = op_b_q;
                end
            end
            StWbRsp: begin
                if (m1_axi_bvalid) begin
                    err_d    = err_q | resp_is_err(m1_axi_bresp);
                    state_d  = StRsReq;
                    araddr_d = ADDR_SUM;
                end
            end
            StRsReq: begin
                if (m1_axi_arready) state_d = StRsRsp;
            end
            StRsRsp: begin
                if (m1_axi_rvalid) begin
                    sum_sh_d = m1_axi_rdata;
                    err_d    = err_q | resp_is_err(m1_axi_rresp);
                    state_d  = StRoReq;
                    araddr_d = ADDR_OVF;
                end
            end
            StRoReq: begin
                if (m1_axi_arready) state_d = StRoRsp;
            end
            StRoRsp: begin
                // Results become visible in the same cycle as done.
                if (m1_axi_rvalid) begin
                    sum_d   = sum_sh_q;
                    ovf_d   = m1_axi_rdata[0];
                    err_d   = err_q | resp_is_err(m1_axi_rresp);
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A stalled channel is abandoned; previous results are kept.
        if (timeout) begin
            state_d   = StDone;
            err_d     = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            sum_d     = sum_q;
            ovf_d     = ovf_q;
        end
    end

    always_ff @(posedge m1_axi_aclk) begin
        if (m1_axi_areset) begin
            state_q   <= StIdle;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            op_b_q    <= '0;
            sum_sh_q  <= '0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            op_b_q    <= op_b_d;
            sum_sh_q  <= sum_sh_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_adder_axi_master.sv
// Bench for adder_axi_master: a cycle-stepped AXI-Lite slave that behaves like the adder
// peripheral (stores the operands it is sent, returns their sum and carry), with configurable
// ready delays and response codes.
module tb_adder_axi_master;

    localparam logic [7:0] BASE = 8'h40;

    logic        clk = 1'b0;
    logic        m1_axi_areset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done, overflow, err;
    logic [31:0] sum;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    adder_axi_master #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (8),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .m1_axi_aclk    (clk),
        .m1_axi_areset  (m1_axi_areset),
        .start          (start),
        .op_a           (op_a),
        .op_b           (op_b),
        .busy           (busy),
        .done           (done),
        .sum            (sum),
        .overflow       (overflow),
        .err            (err),
        .m1_axi_awaddr  (awaddr),
        .m1_axi_awvalid (awvalid),
        .m1_axi_awready (awready),
        .m1_axi_wdata   (wdata),
        .m1_axi_wstrb   (wstrb),
        .m1_axi_wvalid  (wvalid),
        .m1_axi_wready  (wready),
        .m1_axi_bresp   (bresp),
        .m1_axi_bvalid  (bvalid),
        .m1_axi_bready  (bready),
        .m1_axi_araddr  (araddr),
        .m1_axi_arvalid (arvalid),
        .m1_axi_arready (arready),
        .m1_axi_rdata   (rdata),
        .m1_axi_rresp   (rresp),
        .m1_axi_rvalid  (rvalid),
        .m1_axi_rready  (rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave configuration.
    int         aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic [1:0] bresp_cfg [2];
    logic [1:0] rresp_cfg [2];
    int         start_pulse_at = -1;
    bit         reset_in_rsp = 0;

    // Peripheral contents and observed outcome.
    logic [31:0] mem_a = '0, mem_b = '0;
    int          done_cycle;
    logic [31:0] got_sum;
    logic        got_ovf, got_err;
    int          aw_cyc [2];
    int          w_cyc [2];
    int          last_ar_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] periph_read(input logic [7:0] addr);
        logic [32:0] s;
        s = {1'b0, mem_a} + {1'b0, mem_b};
        if (addr == BASE + 8'h08) return s[31:0];
        if (addr == BASE + 8'h0C) return {31'b0, s[32]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awvalid"}, awvalid, 0);
        check({tag, "_wvalid"}, wvalid, 0);
        check({tag, "_bready"}, bready, 0);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_rready"}, rready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_sum"}, sum, 0);
        check({tag, "_awaddr"}, awaddr, 0);
        check({tag, "_araddr"}, araddr, 0);
        check({tag, "_wdata"}, wdata, 0);
        check({tag, "_wstrb"}, wstrb, 4'hF);
    endtask

    // Starts at a negedge; returns at the negedge of the done cycle (or after an abort).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        int          aw_seen, w_seen, ar_seen, naw, nw, nb, nbi, nr;
        bit          b_pend, r_pend, b_pend_n, r_pend_n, finished;
        logic [7:0]  aw_addr_l [2];
        logic [31:0] w_data_l [2];
        logic [31:0] r_data, r_data_n;
        aw_seen = 0; w_seen = 0; ar_seen = 0; naw = 0; nw = 0; nb = 0; nbi = 0; nr = 0;
        b_pend = 0; r_pend = 0; finished = 0; r_data = '0;
        done_cycle = -1;
        op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            start = (cyc == start_pulse_at);
            if (start) begin op_a = ~a; op_b = ~b; end
            if (done) begin
                finished = 1; done_cycle = cyc;
                got_sum = sum; got_ovf = overflow; got_err = err; last_ar_seen = ar_seen;
            end else if (reset_in_rsp && rready) begin
                finished = 1;
                m1_axi_areset = 1'b1; start = 1'b0;
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                @(negedge clk);
                m1_axi_areset = 1'b0;
            end else begin
                check("busy_during_op", busy, 1);
                b_pend_n = b_pend; r_pend_n = r_pend; r_data_n = r_data;
                bvalid = b_pend; bresp = bresp_cfg[nb & 1];
                if (b_pend && bready) begin b_pend_n = 0; nb++; end
                rvalid = r_pend; rdata = r_data; rresp = rresp_cfg[nr & 1];
                if (r_pend && rready) begin r_pend_n = 0; nr++; end
                awready = 1'b0;
                if (awvalid) begin
                    aw_seen++;
                    awready = (aw_seen > aw_dly);
                    check("awaddr", awaddr, BASE + 8'(4 * naw));
                    if (awready) begin
                        aw_addr_l[naw & 1] = awaddr; aw_cyc[naw & 1] = aw_seen;
                        aw_seen = 0; naw++;
                    end
                end
                wready = 1'b0;
                if (wvalid) begin
                    w_seen++;
                    wready = (w_seen > w_dly);
                    check("wdata", wdata, (nw == 0) ? a : b);
                    check("wstrb", wstrb, 4'hF);
                    if (wready) begin
                        w_data_l[nw & 1] = wdata; w_cyc[nw & 1] = w_seen;
                        w_seen = 0; nw++;
                    end
                end
                if (naw > nbi && nw > nbi) begin
                    if (aw_addr_l[nbi & 1] == BASE) mem_a = w_data_l[nbi & 1];
                    else if (aw_addr_l[nbi & 1] == BASE + 8'h04) mem_b = w_data_l[nbi & 1];
                    b_pend_n = 1; nbi++;
                end
                arready = 1'b0;
                if (arvalid) begin
                    ar_seen++;
                    arready = (ar_seen > ar_dly);
                    check("araddr", araddr, BASE + 8'h08 + 8'(4 * (nr + (r_pend ? 1 : 0))));
                    if (arready) begin
                        r_pend_n = 1; r_data_n = periph_read(araddr); ar_seen = 0;
                    end
                end
                b_pend = b_pend_n; r_pend = r_pend_n; r_data = r_data_n;
                @(negedge clk);
            end
        end
        start = 1'b0; awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        if (!finished) check("done_within_budget", 0, 1);
    endtask

    task automatic verify(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic        e;
        int          mx;
        s  = {1'b0, a} + {1'b0, b};
        e  = bresp_cfg[0][1] | bresp_cfg[1][1] | rresp_cfg[0][1] | rresp_cfg[1][1];
        mx = (aw_dly > w_dly) ? aw_dly : w_dly;
        check("done_cycle", done_cycle, 9 + 2 * mx + 2 * ar_dly);
        check("sum", got_sum, s[31:0]);
        check("overflow", got_ovf, s[32]);
        check("err", got_err, e);
        for (int k = 0; k < 2; k++) begin
            check("awvalid_cycles", aw_cyc[k], aw_dly + 1);
            check("wvalid_cycles", w_cyc[k], w_dly + 1);
        end
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    task automatic set_ok();
        aw_dly = 0; w_dly = 0; ar_dly = 0;
        bresp_cfg[0] = 2'b00; bresp_cfg[1] = 2'b00;
        rresp_cfg[0] = 2'b00; rresp_cfg[1] = 2'b00;
    endtask

    initial begin
        logic [31:0] a, b, prev_sum;
        logic        prev_ovf;
        set_ok();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        m1_axi_areset = 1'b0;
        @(negedge clk);

        // 1: zero-wait, 5 + 7.
        run_op(32'd5, 32'd7);
        verify(32'd5, 32'd7);

        // 2: carry out of the top bit.
        run_op(32'hFFFF_FFFF, 32'd1);
        verify(32'hFFFF_FFFF, 32'd1);

        // 3: awready three cycles behind wready.
        aw_dly = 3;
        run_op(32'h1234_5678, 32'h0BAD_F00D);
        verify(32'h1234_5678, 32'h0BAD_F00D);
        set_ok();

        // 4: SLVERR on the operand B write does not abort.
        bresp_cfg[1] = 2'b10;
        run_op(32'd100, 32'd23);
        verify(32'd100, 32'd23);
        set_ok();

        // EXOKAY counts as success.
        rresp_cfg[0] = 2'b01; bresp_cfg[0] = 2'b01;
        run_op(32'hA5A5_0000, 32'h0000_5A5A);
        verify(32'hA5A5_0000, 32'h0000_5A5A);
        set_ok();

        // Randomized operands, delays and responses.
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 2);
            for (int k = 0; k < 2; k++) begin
                bresp_cfg[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
                rresp_cfg[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'b01;
            end
            run_op(a, b);
            verify(a, b);
        end
        set_ok();

        // Stray responses while idle are not accepted.
        bvalid = 1'b1; rvalid = 1'b1;
        @(negedge clk);
        check("stray_bready", bready, 0);
        check("stray_rready", rready, 0);
        check("stray_busy", busy, 0);
        bvalid = 1'b0; rvalid = 1'b0;
        @(negedge clk);

        // 5a: start pulsed while busy is ignored.
        start_pulse_at = 3;
        run_op(32'd40, 32'd2);
        start_pulse_at = -1;
        verify(32'd40, 32'd2);
        for (int i = 0; i < 4; i++) begin
            check("no_second_op_busy", busy, 0);
            check("no_second_op_awvalid", awvalid, 0);
            @(negedge clk);
        end

`ifdef ADDER_MASTER_TIMEOUT_EN
        // 6: arready never comes; watchdog ends the wait after 16 cycles.
        prev_sum = got_sum; prev_ovf = got_ovf;
        ar_dly = 1000;
        run_op(32'd1, 32'd1);
        check("to_arvalid_cycles", last_ar_seen, 16);
        check("to_done_cycle", done_cycle, 21);
        check("to_err", got_err, 1);
        check("to_sum_held", got_sum, prev_sum);
        check("to_ovf_held", got_ovf, prev_ovf);
        @(negedge clk);
        check("to_arvalid_dropped", arvalid, 0);
        set_ok();
`else
        prev_sum = got_sum; prev_ovf = got_ovf;
`endif
        check("sum_held_idle", sum, prev_sum);
        check("ovf_held_idle", overflow, prev_ovf);

        // 5b: reset in RS_RSP returns to idle with cleared outputs and no done.
        reset_in_rsp = 1;
        run_op(32'd9, 32'd9);
        reset_in_rsp = 0;
        check_reset_outputs("midop_reset");
        for (int i = 0; i < 5; i++) begin
            check("no_done_after_reset", done, 0);
            check("idle_after_reset", busy, 0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
